// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce.
// Emits a one-cycle key_valid with the accepted key code.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam logic [1:0]  RES_NONE  = 2'd0;
    localparam logic [1:0]  RES_ONE   = 2'd1;
    localparam logic [1:0]  RES_MULTI = 2'd2;
    localparam logic [15:0] CNT_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_TGT    = 4'(DEBOUNCE);

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic [15:0] cnt;
    logic [1:0]  col;
    logic [1:0]  hits;
    logic [3:0]  first;
    logic [1:0]  last_kind;
    logic [3:0]  last_code;
    logic [3:0]  stable;

    logic        sample;
    logic [3:0]  pressed;
    logic [2:0]  hit_sum;
    logic [1:0]  hits_nxt;
    logic [1:0]  first_row;
    logic [3:0]  first_nxt;
    logic [1:0]  res_kind;
    logic [3:0]  res_code;
    logic        same;
    logic [3:0]  stable_nxt;
    logic        accept;

    assign col_n   = ~(4'b0001 << col);
    assign sample  = (cnt == CNT_LAST);
    assign pressed = ~row_sync;

    always_comb begin
        hit_sum = {1'b0, hits} + {2'b00, pressed[0]} + {2'b00, pressed[1]}
                + {2'b00, pressed[2]} + {2'b00, pressed[3]};
        hits_nxt = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];

        first_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (pressed[r]) first_row = 2'(r);
        end
        // only the first hit of the frame in scan order is remembered
        first_nxt = (hits == 2'd0 && |pressed) ? {first_row, col} : first;

        if (hits_nxt == 2'd0) begin
            res_kind = RES_NONE;
            res_code = 4'd0;
        end else if (hits_nxt == 2'd1) begin
            res_kind = RES_ONE;
            res_code = first_nxt;
        end else begin
            res_kind = RES_MULTI;
            res_code = 4'd0;
        end

        same       = ({res_kind, res_code} == {last_kind, last_code});
        stable_nxt = same ? ((stable == DB_TGT) ? stable : stable + 4'd1) : 4'd1;
        // fire only on the frame where the count first lands on the target
        accept     = (stable_nxt == DB_TGT) && (!same || stable != DB_TGT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            cnt       <= '0;
            col       <= '0;
            hits      <= '0;
            first     <= '0;
            last_kind <= RES_NONE;
            last_code <= '0;
            stable    <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_down  <= 1'b0;
        end else begin
            row_meta  <= row_n;
            row_sync  <= row_meta;
            key_valid <= 1'b0;
            if (sample) begin
                cnt <= '0;
                col <= col + 2'd1;
                if (col == 2'd3) begin
                    hits      <= '0;
                    first     <= '0;
                    last_kind <= res_kind;
                    last_code <= res_code;
                    stable    <= stable_nxt;
                    if (accept) begin
                        if (res_kind == RES_ONE) begin
                            if (!key_down || key_code != res_code) begin
                                key_valid <= 1'b1;
                                key_code  <= res_code;
                                key_down  <= 1'b1;
                            end
                        end else if (res_kind == RES_NONE) begin
                            key_down <= 1'b0;
                        end
                    end
                end else begin
                    hits  <= hits_nxt;
                    first <= first_nxt;
                end
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, step table and key-event scoreboard.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] keys = '0;
    logic        mon_en = 1'b0;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          pulse_frame;
        int          pulse_code;
        int          exp_down;
        int          exp_code;
        string       name;
    } step_t;

    typedef struct {
        int code;
        int at;
    } ev_t;

    ev_t   sb[$];
    step_t steps[14];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // key index r*4+c pulls row r low while column c is strobed
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        steps[0]  = '{16'h0000,  4, 0, 0, 0, 0, "idle"};
        steps[1]  = '{16'h0200, 10, 3, 9, 1, 9, "hold_9"};
        steps[2]  = '{16'h0000,  2, 0, 0, 1, 9, "release_2f"};
        steps[3]  = '{16'h0000,  1, 0, 0, 0, 9, "release_3f"};
        steps[4]  = '{16'h0008,  1, 0, 0, 0, 9, "toggle_p1"};
        steps[5]  = '{16'h0000,  1, 0, 0, 0, 9, "toggle_r1"};
        steps[6]  = '{16'h0008,  1, 0, 0, 0, 9, "toggle_p2"};
        steps[7]  = '{16'h0000,  1, 0, 0, 0, 9, "toggle_r2"};
        steps[8]  = '{16'h0008,  1, 0, 0, 0, 9, "toggle_p3"};
        steps[9]  = '{16'h0000,  1, 0, 0, 0, 9, "toggle_r3"};
        steps[10] = '{16'h0200,  3, 3, 9, 1, 9, "repress_9"};
        steps[11] = '{16'h4010,  5, 0, 0, 1, 9, "multi_4_14"};
        steps[12] = '{16'h0010,  3, 3, 4, 1, 4, "single_4"};
        steps[13] = '{16'h0010,  2, 0, 0, 1, 4, "hold_4"};

        fork
            begin : monitor
                logic       pv;
                logic [3:0] ec;
                ev_t        ev;
                pv = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst_n && mon_en) begin
                        ec = 4'b0001 << ((cyc / SD) % 4);
                        ec = ~ec;
                        check("col_n", int'(col_n), int'(ec));
                        if (key_valid) begin
                            check("valid_width", int'(pv), 0);
                            check("valid_expected", int'(sb.size() > 0), 1);
                            if (sb.size() > 0) begin
                                ev = sb.pop_front();
                                check("valid_cycle", cyc, ev.at);
                                check("valid_code", int'(key_code), ev.code);
                            end
                        end
                        pv = key_valid;
                    end else begin
                        pv = 1'b0;
                    end
                end
            end
        join_none

        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col_n", int'(col_n), 4'b1110);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_down", int'(key_down), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 14; i++) begin
            keys = steps[i].keys;
            if (steps[i].pulse_frame > 0)
                sb.push_back('{steps[i].pulse_code, cyc + FR * steps[i].pulse_frame});
            repeat (FR * steps[i].frames) @(posedge clk);
            #1;
            check({steps[i].name, ".key_down"}, int'(key_down), steps[i].exp_down);
            check({steps[i].name, ".key_code"}, int'(key_code), steps[i].exp_code);
        end

        // reset mid-debounce while key 15 is held, then keep holding
        keys = 16'h8000;
        repeat (2 * FR + 5) @(posedge clk);
        @(negedge clk);
        check("pre_reset_pending", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col_n", int'(col_n), 4'b1110);
        check("mid_rst_key_valid", int'(key_valid), 0);
        check("mid_rst_key_code", int'(key_code), 0);
        check("mid_rst_key_down", int'(key_down), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{15, 3 * FR});
        repeat (3 * FR) @(posedge clk);
        #1;
        check("after_rst.key_down", int'(key_down), 1);
        check("after_rst.key_code", int'(key_code), 15);
        repeat (2 * FR) @(posedge clk);
        #1;
        check("final_pending", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
